uart_tx_arbiter: RTL and testbench

- Shares one UART transmit datapath (serializer + TX FSM) between N byte requesters using round-robin arbitration.
- Sequences each transfer: latches the winning byte, issues a one-cycle start to the transmitter, then waits for the busy/done handshake before arbitrating again.
- Sits between client blocks (command/status/debug sources) and the UART TX core, in the same clk domain.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the
// shared UART TX arbiter, bundled so the arbiter and its environment
// connect through a single port.
//   master : the arbiter (drives grants and the transmitter controls)
//   slave  : requesters plus the UART TX core (drive requests, busy/done)
interface uart_tx_arbiter_if #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int IDX_W = 2
);
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic [IDX_W-1:0] grant_idx;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            tx_done;
    logic            arb_busy;
    logic            timeout_err;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output grant, grant_idx, tx_data, tx_start, arb_busy, timeout_err
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  grant, grant_idx, tx_data, tx_start, arb_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N byte requesters
// with round-robin arbitration. A winner's byte is latched, a one-cycle
// tx_start is issued, and the arbiter then waits for the transmitter's
// busy/done handshake before arbitrating again. All outputs are registered.
//
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a transfer that
// has not completed within TIMEOUT cycles of leaving LOAD; the abort pulses
// timeout_err and demotes the stuck requester. Without the macro no counter
// is built, timeout_err is tied low and the arbiter waits for tx_done
// indefinitely.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [N-1:0]     grant_q;
    logic [DW-1:0]    tx_data_q;
    logic             tx_start_q;
    logic             arb_busy_q;
    logic             timeout_err_q;

    logic [DW-1:0]    req_bytes [N];
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             expired;

    // The counter reaches TIMEOUT at the end of the current wait cycle.
    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Split the packed request bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_bytes[i] = bus.req_data[i*DW +: DW];
        end
    end

    // Round-robin pick: first requester at or after ptr+1, wrapping modulo N.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the unassigned paths would infer latches.
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (bus.req[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Arbitration / handshake FSM; every output is registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(N - 1);
            grant_idx_q   <= IDX_W'(N - 1);
            grant_q       <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            arb_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; these
            // defaults make the pulse outputs last one cycle, and any later
            // assignment in this block overrides them.
            grant_q       <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_q     <= LOAD;
                        grant_q     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        grant_idx_q <= win_idx;
                        tx_data_q   <= req_bytes[win_idx];
                        tx_start_q  <= 1'b1;
                        arb_busy_q  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end

                LOAD: begin
                    state_q <= WAIT_BUSY;
                end

                WAIT_BUSY, WAIT_DONE: begin
                    if (bus.tx_done) begin
                        // Completion (also covers done arriving with or before busy).
                        state_q    <= IDLE;
                        ptr_q      <= grant_idx_q;
                        arb_busy_q <= 1'b0;
                    end else if (state_q == WAIT_BUSY && bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
                    // Done in the expiry cycle counts as completion, not an abort.
                    if (!bus.tx_done && expired) begin
                        state_q       <= IDLE;
                        ptr_q         <= grant_idx_q;
                        arb_busy_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end
`endif
                end

                default: begin
                    state_q    <= IDLE;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.arb_busy    = arb_busy_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed stimulus for uart_tx_arbiter.
// Requesters are byte FIFOs that hold req while non-empty; a transmitter
// model answers each tx_start with a random busy/done pattern. A reference
// model tracks only "free / transfer outstanding", the round-robin pointer
// and the last grant, and predicts every output on every cycle.
module tb_uart_tx_arbiter;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N), .DW(DW), .IDX_W(IDX_W)) bus ();

    uart_tx_arbiter #(.N(N), .DW(DW), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester byte FIFOs.
    logic [DW-1:0] fifo [N][DEPTH];
    int            rd   [N];
    int            cnt  [N];

    // Transmitter response plan, one {busy,done} entry per cycle.
    logic [1:0] plan [$];
    bit         tx_silent;
    int         force_mode;

    // Reference model state.
    bit            m_idle;
    int            m_ptr;
    int            m_last;
    int            m_age;
    logic [DW-1:0] m_data;

    logic [N-1:0]  drv_req;
    logic          drv_done;
    logic [DW-1:0] obs     [$];
    logic [DW-1:0] exp_seq [$];

    // First requester after p (mod N) that is requesting, or -1.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (cnt[i] > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input int i, input logic [DW-1:0] b);
        if (cnt[i] < DEPTH) begin
            fifo[i][(rd[i] + cnt[i]) % DEPTH] = b;
            cnt[i]++;
        end
    endtask

    // Plan a transmitter answer: mode 1 = done with busy, 2 = done without busy.
    task automatic plan_frame();
        int mode;
        int db;
        int dd;
        mode = (force_mode >= 0) ? force_mode : int'($urandom_range(0, 3));
        plan.push_back(2'b00);                  // LOAD cycle
        db = int'($urandom_range(0, 2));
        repeat (db) plan.push_back(2'b00);
        case (mode)
            1: plan.push_back(2'b11);
            2: plan.push_back(2'b01);
            default: begin
                dd = int'($urandom_range(1, 4));
                repeat (dd) plan.push_back(2'b10);
                plan.push_back(2'b11);
            end
        endcase
    endtask

    // Drive one cycle of inputs, clock it, then predict and check all outputs.
    task automatic step();
        logic [1:0]   bd;
        logic [N-1:0] exp_grant;
        bit           exp_start;
        bit           exp_to;
        int           w;
        for (int i = 0; i < N; i++) begin
            drv_req[i] = (cnt[i] > 0);
            bus.req_data[i*DW +: DW] = (cnt[i] > 0) ? fifo[i][rd[i]] : '0;
        end
        bd = 2'b00;
        if (plan.size() > 0) bd = plan.pop_front();
        drv_done     = bd[0];
        bus.req      = drv_req;
        bus.tx_busy  = bd[1];
        bus.tx_done  = bd[0];

        @(posedge clk);
        #1;

        exp_grant = '0;
        exp_start = 1'b0;
        exp_to    = 1'b0;
        if (m_idle) begin
            w = pick(drv_req, m_ptr);
            if (w >= 0) begin
                exp_grant[w] = 1'b1;
                exp_start    = 1'b1;
                m_idle       = 1'b0;
                m_last       = w;
                m_age        = 0;
                m_data       = fifo[w][rd[w]];
                rd[w]        = (rd[w] + 1) % DEPTH;
                cnt[w]--;
                if (!tx_silent) plan_frame();
            end
        end else begin
            m_age++;
            if (drv_done) begin
                m_idle = 1'b1;
                m_ptr  = m_last;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (m_age == TIMEOUT + 1) begin
                m_idle = 1'b1;
                m_ptr  = m_last;
                exp_to = 1'b1;
            end
`endif
        end

        if (bus.tx_start === 1'b1) obs.push_back(bus.tx_data);
        check("grant",       32'(bus.grant),       32'(exp_grant));
        check("tx_start",    32'(bus.tx_start),    32'(exp_start));
        check("grant_idx",   32'(bus.grant_idx),   32'(m_last));
        check("tx_data",     32'(bus.tx_data),     32'(m_data));
        check("arb_busy",    32'(bus.arb_busy),    32'(!m_idle));
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((!m_idle || pending()) && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(m_idle && !pending()), 32'd1);
    endtask

    task automatic check_obs(input string tag);
        check({tag, "_len"}, 32'(obs.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < obs.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(obs[i]), 32'(exp_seq[i]));
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_grant",     32'(bus.grant),       32'd0);
        check("rst_tx_start",  32'(bus.tx_start),    32'd0);
        check("rst_arb_busy",  32'(bus.arb_busy),    32'd0);
        check("rst_grant_idx", 32'(bus.grant_idx),   32'(N - 1));
        check("rst_tx_data",   32'(bus.tx_data),     32'd0);
        check("rst_timeout",   32'(bus.timeout_err), 32'd0);
        for (int i = 0; i < N; i++) begin
            rd[i]  = 0;
            cnt[i] = 0;
        end
        plan.delete();
        obs.delete();
        tx_silent    = 1'b0;
        force_mode   = -1;
        m_idle       = 1'b1;
        m_ptr        = N - 1;
        m_last       = N - 1;
        m_age        = 0;
        m_data       = '0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;

        // Single requester, single byte.
        do_reset();
        push(0, 8'hA5);
        run_until_idle(50);
        exp_seq = '{8'hA5};
        check_obs("single");

        // All four requesting, requester 0 asks for a second byte.
        do_reset();
        push(0, 8'h11); push(0, 8'h11);
        push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
        run_until_idle(200);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        check_obs("rr_all");

        // Pointer at 1, requests 0 and 2: 2 first, then wrap to 0.
        do_reset();
        push(1, 8'h5A);
        run_until_idle(50);
        obs.delete();
        push(0, 8'h77); push(2, 8'h99);
        run_until_idle(100);
        exp_seq = '{8'h99, 8'h77};
        check_obs("wrap");

        // Requester 3 arrives while requester 0's frame is in flight.
        do_reset();
        force_mode = 0;
        push(0, 8'h3C);
        repeat (3) step();
        push(3, 8'hC3);
        run_until_idle(100);
        exp_seq = '{8'h3C, 8'hC3};
        check_obs("midframe");

        // done together with busy, then done with no busy at all.
        do_reset();
        force_mode = 1;
        push(2, 8'hE1);
        run_until_idle(50);
        force_mode = 2;
        push(1, 8'hE2);
        run_until_idle(50);
        force_mode = -1;
        push(0, 8'hE3);
        run_until_idle(50);
        exp_seq = '{8'hE1, 8'hE2, 8'hE3};
        check_obs("early_done");

        // Silent transmitter: wait forever, or abort with the watchdog built in.
        do_reset();
        tx_silent = 1'b1;
        push(1, 8'h42); push(2, 8'h24);
        repeat (TIMEOUT + 8) step();
`ifdef UART_ARB_TIMEOUT_EN
        exp_seq = '{8'h42, 8'h24};
`else
        exp_seq = '{8'h42};
`endif
        check_obs("stall");

        // Reset right after a grant, then normal service from requester 0.
        do_reset();
        push(3, 8'h5C);
        step();
        do_reset();
        push(0, 8'h0F); push(3, 8'hF0);
        run_until_idle(100);
        exp_seq = '{8'h0F, 8'hF0};
        check_obs("post_reset");

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) push(int'($urandom_range(0, N - 1)), 8'($urandom));
            step();
        end
        run_until_idle(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
